serial_addsub: RTL



---
 rtl/serial_addsub.sv | 121 ++++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell consumes one operand bit per
// clock, LSB first, behind a start/busy/done handshake. Subtraction is a + ~b + 1.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_MSB  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    count_q;
  logic             carry_q;
  logic             cin_msb_q;
  logic             carryout_q;
  logic             overflow_q;
  logic             busy_q;
  logic             done_q;

  // The single full-adder cell shared by every bit position.
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] acc_d;

  assign bit_s = opa_q[0] ^ opb_q[0] ^ carry_q;
  assign bit_c = (opa_q[0] & opb_q[0]) | (opa_q[0] & carry_q) | (opb_q[0] & carry_q);
  assign acc_d = {bit_s, acc_q[WIDTH-1:1]};

  // NOTE: every register here uses non-blocking assignment so all flops sample
  // the same pre-edge values; the datapath registers are reset too, because
  // reset must clear the visible result and discard any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      count_q    <= '0;
      carry_q    <= 1'b0;
      cin_msb_q  <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            opa_q   <= a;
            opb_q   <= sub ? ~b : b;
            carry_q <= sub;
            count_q <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end

        RUN: begin
          acc_q   <= acc_d;
          opa_q   <= opa_q >> 1;
          opb_q   <= opb_q >> 1;
          carry_q <= bit_c;
          // Carry out of bit WIDTH-2 is the carry into the MSB.
          if (count_q == PRE_MSB) begin
            cin_msb_q <= bit_c;
          end
          if (count_q == LAST_BIT) begin
            result_q   <= acc_d;
            carryout_q <= bit_c;
            overflow_q <= cin_msb_q ^ bit_c;
            state_q    <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule
